mul_seq: RTL
============

Name: mul_seq

Overview:
Multi-cycle 32x32->64 shift-add multiplier. It is the inverse-operation partner of the team's divider and sits beside it in the execute stage as the HI/LO producer for mult/multu.
Adds a start/busy/done handshake so the pipeline can stall on it.
Signed operands use sign-magnitude: operand magnitudes are multiplied unsigned, then the product is conditionally negated.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits.
STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4; WIDTH % STEP == 0.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy==0
signed_op  input  1  1 = treat a/b as two's complement, 0 = unsigned
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
busy  output  1  operation in flight; start is ignored while high
done  output  1  one-cycle pulse; hi/lo are valid from this cycle on
hi  output  WIDTH  product[2*WIDTH-1:WIDTH]
lo  output  WIDTH  product[WIDTH-1:0]

Behaviour:
- Reset (async, while rst=1): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulator, counter and negate flag all 0.
- Iteration count N = WIDTH/STEP.
- States: IDLE, CALC, FIX.
- IDLE: on an edge with start=1:
  - latch |a| and |b| (magnitudes only if signed_op, else raw values);
  - neg = signed_op & (a[MSB]^b[MSB]);
  - clear the accumulator; cnt=0; go to CALC.
  - This edge is E0.
- CALC: each edge adds (mcand * low STEP bits of the multiplier) << (cnt*STEP) into the 2W accumulator, shifts the multiplier right by STEP, and increments cnt. After the edge with cnt==N-1 (edge EN), go to FIX.
- FIX: at edge E(N+1):
  - hi:lo = neg ? -acc : acc (2W-bit two's complement);
  - done=1 for that cycle only; state returns to IDLE.
- Latency: start edge to done-high is N+1 edges (33 for the defaults).
- busy = (state != IDLE). It is high from after E0 through E(N+1) and low in the done cycle.
- Back-to-back: start=1 in the done cycle is accepted. That edge is the new E0, so done falls and busy rises on the same edge.
- start while busy: ignored; operands and signed_op changing mid-operation have no effect.
- hi/lo hold the last result until the next FIX edge or reset. They are not cleared by start.
- |0x80000000| = 0x80000000, taken as an unsigned WIDTH-bit magnitude, with no overflow. The accumulator is 2W bits, so no carry is lost.
- Zero operand: the full N iterations still run; no early exit, so latency is constant.
- rst asserted mid-operation: immediate abort to the reset values; no done pulse for the aborted operation.

Decomposition:
- Shared package mul_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, FIX} mul_state_t;
  - localparam MUL_WIDTH = 32;
  - typedef logic [2*MUL_WIDTH-1:0] mul_prod_t.
- One sub-module, mul_step: combinational partial product, mcand * multiplier[STEP-1:0] zero-extended to 2W. It is instantiated once and shifted by the parent.

Test Plan:
- unsigned 3 x 5 -> done exactly 33 edges after the start edge, hi=0x00000000, lo=0x0000000F; busy low in the done cycle.
- unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- signed -2 x 3 (0xFFFFFFFE, 0x00000003) -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Issue 7x6. Pulse start with 9x9 at edge E5 (busy). Then start 2x2 in the done cycle.
  - Expect the 9x9 request ignored and first result lo=42.
  - Second result lo=4 exactly 33 edges after the done cycle.
- rst pulsed (not clock-aligned) at edge E10 of an operation -> busy=0, done=0, hi=lo=0 immediately; no done for 100 cycles without start.
- Random 1000 ops for STEP=1,2,4 with signed_op random -> {hi,lo} matches the reference 64-bit product.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and product type for the sequential multiplier
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} mul_state_t;
  localparam int MUL_WIDTH = 32;
  typedef logic [2*MUL_WIDTH-1:0] mul_prod_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one partial product, multiplicand times the low STEP multiplier bits, zero-extended to 2W
module mul_step #(
  parameter int WIDTH = 32,
  parameter int STEP = 1
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [STEP-1:0]    mbits,
  output logic [2*WIDTH-1:0] pp
);
  assign pp = (2*WIDTH)'(mcand) * (2*WIDTH)'(mbits);
endmodule

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle sign-magnitude shift-add multiplier with start/busy/done handshake
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int N = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(2 * WIDTH);
  mul_state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_q, acc_d, pp, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shamt;
  logic neg_q, neg_d, done_q, done_d;
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
  assign shamt = SW'(cnt_q) * SW'(STEP);
  assign res = neg_q ? -acc_q : acc_q;
  mul_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .mcand(mcand_q),
    .mbits(mplier_q[STEP-1:0]),
    .pp(pp)
  );
  // next-state: latch magnitudes on start, accumulate shifted partial products, then sign-fix into hi/lo
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      mcand_d = a_mag;
      mplier_d = b_mag;
      neg_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d = '0;
      cnt_d = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      acc_d = acc_q + (pp << shamt);
      mplier_d = mplier_q >> STEP;
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(N - 1)) ? FIX : CALC;
    end else if (state_q == FIX) begin
      {hi_d, lo_d} = res;
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
